// File: rtl/ex_stage_pkg.sv
// Shared defines for the MIPS execute stage: bus widths, ALU op codes,
// result-class selects, divider state encoding and the HI/LO bundle.
package ex_stage_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int AluOpBus   = 8;
   localparam int AluSelBus  = 3;

   localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

   localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'h24;
   localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'h25;
   localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'h26;
   localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'h27;
   localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'h7C;
   localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'h02;
   localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'h03;
   localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'h2A;
   localparam logic [AluOpBus-1:0] EXE_SLTU_OP = 8'h2B;
   localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'h21;
   localparam logic [AluOpBus-1:0] EXE_SUBU_OP = 8'h23;
   localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'h1A;
   localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'h1B;

   localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'd0;
   localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'd1;
   localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'd2;
   localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      DIV_ZERO,
      BUSY,
      DONE
   } div_state_e;

   typedef struct packed {
      logic [RegBus-1:0] hi;
      logic [RegBus-1:0] lo;
   } hilo_t;

   function automatic logic [RegBus-1:0] neg_if(
      input logic [RegBus-1:0] v,
      input logic              neg
   );
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master: pipeline side (drives ID/EX fields, flush); slave: ex_stage.
interface ex_stage_if;
   import ex_stage_pkg::*;

   logic [AluOpBus-1:0]   aluop_i;
   logic [AluSelBus-1:0]  alusel_i;
   logic [RegBus-1:0]     reg1_i;
   logic [RegBus-1:0]     reg2_i;
   logic [RegAddrBus-1:0] wd_i;
   logic                  wreg_i;
   logic                  flush_i;
   logic [RegAddrBus-1:0] wd_o;
   logic                  wreg_o;
   logic [RegBus-1:0]     wdata_o;
   logic                  whilo_o;
   logic [RegBus-1:0]     hi_o;
   logic [RegBus-1:0]     lo_o;
   logic                  stallreq_o;

   modport master (
      output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
   );

   modport slave (
      input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
   );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative 32-step restoring divider (DIV/DIVU) with sign fix-up.
// in: start, signed_div, op_a, op_b, annul; out: result (hi/lo), ready.
module div_unit
   import ex_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_div,
   input  logic [RegBus-1:0] op_a,
   input  logic [RegBus-1:0] op_b,
   input  logic              annul,
   output hilo_t             result,
   output logic              ready
);

   div_state_e        state, state_nxt;
   logic [4:0]        cnt;
   logic [64:0]       acc;
   logic [RegBus-1:0] dvs;
   logic              neg_q, neg_r;
   logic              a_neg, b_neg;
   logic [33:0]       sh, diff;

   assign a_neg = signed_div & op_a[31];
   assign b_neg = signed_div & op_b[31];

   // acc = {partial remainder, dividend bits / quotient bits}
   assign sh   = {acc[64:32], acc[31]};
   assign diff = sh - {2'b00, dvs};

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (start)
               state_nxt = (op_b == ZeroWord) ? DIV_ZERO : BUSY;
         DIV_ZERO: state_nxt = DONE;
         BUSY:
            if (cnt == 5'd31)
               state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (annul)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 5'd0;
         acc   <= '0;
         dvs   <= ZeroWord;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               cnt <= 5'd0;
               if (start) begin
                  acc   <= {33'd0, neg_if(op_a, a_neg)};
                  dvs   <= neg_if(op_b, b_neg);
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
               end
            end
            DIV_ZERO: acc <= '0;
            BUSY: begin
               cnt <= cnt + 5'd1;
               // borrow out means the divisor did not fit: restore
               if (diff[33])
                  acc <= {sh[32:0], acc[30:0], 1'b0};
               else
                  acc <= {diff[32:0], acc[30:0], 1'b1};
            end
            default: ;
         endcase
      end
   end

   assign ready     = (state == DONE);
   assign result.hi = ready ? neg_if(acc[63:32], neg_r) : ZeroWord;
   assign result.lo = ready ? neg_if(acc[31:0], neg_q) : ZeroWord;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle logic/shift/arith ALU plus divider.
// clk, rst; ex (slave): ID/EX fields in, EX/MEM result, HI/LO, stall out.
module ex_stage
   import ex_stage_pkg::*;
(
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave ex
);

   logic [RegBus-1:0] logic_res, shift_res, arith_res, alu_res;
   logic [4:0]        sa;
   logic              is_div, div_rdy;
   hilo_t             div_res;

   assign sa = ex.reg1_i[4:0];

   always_comb begin
      logic_res = ZeroWord;
      unique case (ex.aluop_i)
         EXE_AND_OP: logic_res = ex.reg1_i & ex.reg2_i;
         EXE_OR_OP:  logic_res = ex.reg1_i | ex.reg2_i;
         EXE_XOR_OP: logic_res = ex.reg1_i ^ ex.reg2_i;
         EXE_NOR_OP: logic_res = ~(ex.reg1_i | ex.reg2_i);
         default:    logic_res = ZeroWord;
      endcase
   end

   always_comb begin
      shift_res = ZeroWord;
      unique case (ex.aluop_i)
         EXE_SLL_OP: shift_res = ex.reg2_i << sa;
         EXE_SRL_OP: shift_res = ex.reg2_i >> sa;
         EXE_SRA_OP: shift_res = $signed(ex.reg2_i) >>> sa;
         default:    shift_res = ZeroWord;
      endcase
   end

   always_comb begin
      arith_res = ZeroWord;
      unique case (ex.aluop_i)
         EXE_ADDU_OP: arith_res = ex.reg1_i + ex.reg2_i;
         EXE_SUBU_OP: arith_res = ex.reg1_i - ex.reg2_i;
         EXE_SLT_OP:
            arith_res = {31'd0, $signed(ex.reg1_i) < $signed(ex.reg2_i)};
         EXE_SLTU_OP:
            arith_res = {31'd0, ex.reg1_i < ex.reg2_i};
         default:     arith_res = ZeroWord;
      endcase
   end

   always_comb begin
      alu_res = ZeroWord;
      unique case (1'b1)
         (ex.alusel_i == EXE_RES_LOGIC): alu_res = logic_res;
         (ex.alusel_i == EXE_RES_SHIFT): alu_res = shift_res;
         (ex.alusel_i == EXE_RES_ARITH): alu_res = arith_res;
         default:                        alu_res = ZeroWord;
      endcase
   end

   assign is_div = (ex.aluop_i == EXE_DIV_OP) | (ex.aluop_i == EXE_DIVU_OP);

   div_unit u_div (
      .clk        (clk),
      .rst        (rst),
      .start      (is_div),
      .signed_div (ex.aluop_i == EXE_DIV_OP),
      .op_a       (ex.reg1_i),
      .op_b       (ex.reg2_i),
      .annul      (ex.flush_i),
      .result     (div_res),
      .ready      (div_rdy)
   );

   // ID/EX is frozen while stalled, so a divide stays visible until DONE
   assign ex.stallreq_o = ~rst & is_div & ~div_rdy & ~ex.flush_i;
   assign ex.wd_o       = rst ? '0 : ex.wd_i;
   assign ex.wreg_o     = ~rst & ex.wreg_i;
   assign ex.wdata_o    = rst ? ZeroWord : alu_res;
   assign ex.whilo_o    = ~rst & div_rdy;
   assign ex.hi_o       = rst ? ZeroWord : div_res.hi;
   assign ex.lo_o       = rst ? ZeroWord : div_res.lo;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the decoded operation, operands and destination held in the ID/EX pipeline register, and produces the write-back result for the EX/MEM register. Logic, shift and add/sub/compare instructions complete combinationally in one cycle. DIV/DIVU run on an iterative 32-step divider that raises a stall request to the pipeline controller until the HI/LO result is ready.

## Interface
- Parameters: none. All widths come from the shared defines package: RegBus 32, RegAddrBus 5, AluOpBus 8, AluSelBus 3.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  operation code from ID/EX
- alusel_i  in  3  result-class select from ID/EX
- reg1_i  in  32  operand 1; for shifts, bits [4:0] give the shift amount
- reg2_i  in  32  operand 2; the value being shifted for shifts
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- flush_i  in  1  annuls any in-progress division
- wd_o  out  5  destination address to EX/MEM
- wreg_o  out  1  register write enable to EX/MEM
- wdata_o  out  32  register write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI write value (remainder)
- lo_o  out  32  LO write value (quotient)
- stallreq_o  out  1  request to freeze IF/ID/EX

## Operation
- Logic class (alusel LOGIC): AND, OR, XOR and NOR of reg1_i and reg2_i.
- Shift class (alusel SHIFT): shift reg2_i by reg1_i[4:0].
  - SLL and SRL fill with zeros.
  - SRA replicates reg2_i[31].
- Arithmetic class (alusel ARITH):
  - ADDU and SUBU are modulo 2^32 and raise no overflow.
  - SLT is a signed compare; SLTU is unsigned. The result is 32'd1 or 32'd0.
- Result mux on alusel_i. NOP or an unknown alusel gives wdata_o = 0. wd_o and wreg_o pass through wd_i and wreg_i.
- Divider FSM states: IDLE, DIV_ZERO, BUSY, DONE.
  - IDLE goes to BUSY when aluop_i is DIV or DIVU and reg2_i ≠ 0. It goes to DIV_ZERO when reg2_i = 0.
  - DIV_ZERO always goes to DONE.
  - BUSY performs one restoring shift-subtract step per cycle, counter 0..31. It goes to DONE after step 31.
  - DONE always goes to IDLE.
  - flush_i in any state forces IDLE on the next edge and drops stallreq_o in the same cycle.
- stallreq_o = 1 in IDLE while a DIV/DIVU is present, and in DIV_ZERO and BUSY. It is 0 in DONE.
  - While stalled, the controller holds ID/EX, so the inputs stay stable.
- Sign handling for DIV:
  - Take magnitudes of negative operands before dividing.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives quotient 0x80000000 and remainder 0.
- Divide by zero gives HI = 0 and LO = 0.
- whilo_o = 1 only in DONE, with hi_o = remainder and lo_o = quotient. Otherwise whilo_o = 0 and hi_o = lo_o = 0.
- DIV/DIVU carry wreg_i = 0 from decode, so wdata_o is 0 for them.
- Reset: FSM goes to IDLE, counter to 0, divider datapath registers to 0. While rst = 1, all outputs are forced to 0.

## Timing
- Single-cycle classes: outputs are a combinational function of the inputs, with zero-cycle latency.
- DIV/DIVU with a nonzero divisor occupies EX for 34 cycles: 1 in IDLE, 32 in BUSY, 1 in DONE. stallreq_o is high for the first 33.
- Divide by zero takes 3 cycles: IDLE, DIV_ZERO, DONE.
- The instruction in EX advances at the end of DONE. The next cycle's state is IDLE, so back-to-back divides each start cleanly and a finished divide is never re-executed.
- If rst is asserted mid-division, the FSM is in IDLE after that edge with no HI/LO write.

## Structure
- Shared defines package holds:
  - EXE_*_OP codes: AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03, SLT 8'h2A, SLTU 8'h2B, ADDU 8'h21, SUBU 8'h23, DIV 8'h1A, DIVU 8'h1B.
  - EXE_RES_* selects: NOP 0, LOGIC 1, SHIFT 2, ARITH 4.
  - ZeroWord.
- One sub-module, div_unit, contains the FSM, counter and 65-bit shift-subtract register. Its interface is start/signed/opA/opB/annul in and result/ready out. ex_stage instantiates it alongside the combinational ALU.

## Test plan
- OR: reg1 = 0x0000FF00, reg2 = 0x00F0000F, wd = 5, wreg = 1 -> same cycle wdata_o = 0x00F0FF0F, wd_o = 5, wreg_o = 1, stallreq_o = 0.
- SRA: reg1 = 4, reg2 = 0x80000000 -> wdata_o = 0xF8000000. SLT with reg1 = 0xFFFFFFFF, reg2 = 1 -> 1. SLTU with the same operands -> 0.
- DIV: reg1 = -7, reg2 = 2 -> stallreq_o high for 33 cycles, then one cycle with whilo_o = 1, lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
- DIVU: reg1 = 100, reg2 = 0 -> stallreq_o high for 2 cycles, then whilo_o = 1 with hi_o = lo_o = 0.
- Two back-to-back DIVU 10/3: each produces lo = 3, hi = 1, with exactly one whilo_o pulse per divide.
- flush_i asserted at BUSY step 10 -> stallreq_o drops immediately, FSM is in IDLE next cycle, no whilo_o pulse. The same check applies to rst asserted mid-division.
